mem_line_server: RTL and testbench
==================================

// Module: mem_line_server
// PURPOSE
//  Main-memory responder for the instruction and data caches: serves line fills on two read ports
//  (I-side, D-side) and dirty-line writebacks on one write port (D-side).
//  - Fixed, parameterised access latency; one transaction in service at a time.
//  - Level-held request / one-cycle-pulse response protocol; sits between both caches and the backing array.
// PARAMETERS
//  ARCH_BITS    32    address width / word width
//  LINE_BITS    128   memory line width (one cache line)
//  DEPTH_LOG2   12    log2 of number of lines stored (4096 lines = 64 KiB)
//  LATENCY      4     cycles from request accept to response pulse (>=1)
// PORTS
//  clk         in   1          clock
//  rst         in   1          synchronous reset, active-high
//  i_rd_req    in   1          I-cache fill request, held high until i_rd_valid
//  i_rd_addr   in   ARCH_BITS  I-cache fill byte address
//  i_rd_data   out  LINE_BITS  fill line for I-cache
//  i_rd_valid  out  1          one-cycle pulse: i_rd_data valid, request complete
//  d_rd_req    in   1          D-cache fill request, held high until d_rd_valid
//  d_rd_addr   in   ARCH_BITS  D-cache fill byte address
//  d_rd_data   out  LINE_BITS  fill line for D-cache
//  d_rd_valid  out  1          one-cycle pulse: d_rd_data valid
//  d_wr_req    in   1          writeback request, held high until d_wr_ack
//  d_wr_addr   in   ARCH_BITS  writeback line-aligned byte address
//  d_wr_line   in   LINE_BITS  writeback data
//  d_wr_ack    out  1          one-cycle pulse: line committed to array
// BEHAVIOUR
//  - Line index = addr[OFF+DEPTH_LOG2-1:OFF], OFF = log2(LINE_BITS/8) = 4; low OFF bits and bits above
//    the index are ignored, so out-of-range addresses wrap.
//  - FSM states: IDLE, WAIT, RESP.
//  - IDLE: if any req is high at posedge, grant one, latch index (and d_wr_line for writes),
//    load cnt = LATENCY-1 -> WAIT (or -> RESP directly if LATENCY==1).
//  - WAIT: cnt decrements each cycle; at cnt==1 -> RESP. RESP is therefore entered LATENCY cycles after accept.
//  - RESP: exactly one of i_rd_valid / d_rd_valid / d_wr_ack is high for one cycle.
//    - Read data is registered and driven in the same cycle; a write commits to the array at the end of the RESP cycle.
//    - Next state is always IDLE (one turnaround cycle; no accept in RESP), giving the requester time to drop req.
//  - Arbitration in IDLE:
//    - d_wr_req has absolute priority (an evicting D-cache raises d_wr_req and d_rd_req together; the writeback
//      must finish before the refill).
//    - Between the two read ports: round-robin on the last granted read port; after reset, D-side wins ties.
//  - Inputs are sampled only at accept; later changes to addr/line during WAIT have no effect.
//  - Request withdrawn before response: the transaction still completes (write still commits, read pulse still
//    issued); the requester ignores it.
//  - Read-after-write to the same line: the read accepted after the write's RESP returns the new data.
//  - Outputs at reset: all valid/ack = 0; i_rd_data = d_rd_data = 0; FSM = IDLE; cnt = 0; rr pointer = D.
//    Array contents are not cleared by reset.
//  - Reset mid-transaction: transaction dropped, no pulse, uncommitted write lost; requester re-requests.
//  - *_rd_data hold their last value between pulses.
// CONFIGURATION
//  - MEM_LINE_SERVER_STATS_EN defined: adds output ports
//    - stat_rd_cnt [31:0]: +1 per read RESP
//    - stat_wr_cnt [31:0]: +1 per write RESP
//    - stat_busy_cyc [31:0]: +1 per cycle not in IDLE
//    All three reset to 0, wrap at 2^32, saturate never.
//  - Not defined: ports and counters absent; behaviour otherwise identical.
// STRUCTURE
//  - mem_pkg: ARCH_BITS, LINE_BITS, OFF = log2(LINE_BITS/8), grant_t enum {GNT_NONE, GNT_IRD, GNT_DRD, GNT_DWR},
//    fsm_t enum {IDLE, WAIT, RESP}.
//  - Sub-module mem_line_arbiter: combinational priority + registered round-robin pointer; outputs grant_t.
//  - The array, FSM and latency counter stay in mem_line_server.
// TESTING
//  - Single I fill: preload line 0x010 = 0xA5..; i_rd_req, addr 0x100 -> i_rd_valid pulse exactly 4 cycles
//    after accept, i_rd_data = preload.
//  - Eviction order: d_wr_req (addr 0x200, line 0xDEAD..) + d_rd_req (0x300) same cycle -> d_wr_ack first;
//    d_rd_valid >= 5 cycles later; read of 0x200 then returns 0xDEAD..
//  - Fairness: i_rd_req and d_rd_req held continuously -> grants alternate D, I, D, I; no port waits
//    more than 2 services.
//  - Boundary: LATENCY=1 -> pulse 1 cycle after accept; addr 0xFFFF_0010 aliases index 0x001.
//  - Reset at cnt==2 during write of line 0x040 -> no ack, array line 0x040 unchanged, FSM IDLE next cycle.
//  - STATS_EN: 3 reads + 2 writes -> stat_rd_cnt = 3, stat_wr_cnt = 2, stat_busy_cyc = 5*(LATENCY).

Source files
------------

// File: rtl/mem_pkg.sv
// mem_pkg: shared widths, line offset and the grant / FSM encodings for the memory line server.
package mem_pkg;
    localparam int ARCH_BITS = 32;
    localparam int LINE_BITS = 128;
    localparam int OFF = $clog2(LINE_BITS / 8);
    typedef enum logic [1:0] {GNT_NONE, GNT_IRD, GNT_DRD, GNT_DWR} grant_t;
    typedef enum logic [1:0] {IDLE, WAIT, RESP} fsm_t;
endpackage

// File: rtl/mem_line_arbiter.sv
// mem_line_arbiter: writeback-first priority, round-robin between the two fill ports.
module mem_line_arbiter
    import mem_pkg::*;
(
    input  logic   clk,
    input  logic   rst,
    input  logic   iRdReq,
    input  logic   dRdReq,
    input  logic   dWrReq,
    input  logic   accept,
    output grant_t grant
);
    logic prefD;
    always_comb grant = dWrReq ? GNT_DWR :
                        (dRdReq && (prefD || !iRdReq)) ? GNT_DRD :
                        iRdReq ? GNT_IRD : GNT_NONE;
    // The read port that just won loses the next tie.
    always_ff @(posedge clk) begin
        if (rst)
            prefD <= 1'b1;
        else if (accept && (grant == GNT_IRD || grant == GNT_DRD))
            prefD <= grant == GNT_IRD;
    end
endmodule

// File: rtl/mem_line_server.sv
// mem_line_server: fixed-latency line store serving I/D fills and D writebacks, one at a time.
// Optional MEM_LINE_SERVER_STATS_EN adds read/write/busy-cycle counters.
module mem_line_server
    import mem_pkg::*;
#(
    parameter int DEPTH_LOG2 = 12,
    parameter int LATENCY = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 i_rd_req,
    input  logic [ARCH_BITS-1:0] i_rd_addr,
    output logic [LINE_BITS-1:0] i_rd_data,
    output logic                 i_rd_valid,
    input  logic                 d_rd_req,
    input  logic [ARCH_BITS-1:0] d_rd_addr,
    output logic [LINE_BITS-1:0] d_rd_data,
    output logic                 d_rd_valid,
    input  logic                 d_wr_req,
    input  logic [ARCH_BITS-1:0] d_wr_addr,
    input  logic [LINE_BITS-1:0] d_wr_line,
    output logic                 d_wr_ack
`ifdef MEM_LINE_SERVER_STATS_EN
    ,
    output logic [31:0]          stat_rd_cnt,
    output logic [31:0]          stat_wr_cnt,
    output logic [31:0]          stat_busy_cyc
`endif
);
    localparam int CW = $clog2(LATENCY + 1);
    fsm_t state, nextState;
    grant_t grant, curGnt, rdGnt;
    logic accept;
    logic [CW-1:0] cnt;
    logic [ARCH_BITS-1:0] reqAddr;
    logic [DEPTH_LOG2-1:0] idx, rdIdx;
    logic [LINE_BITS-1:0] wrLine;
    logic [LINE_BITS-1:0] mem [2**DEPTH_LOG2];
    logic unusedAddr;

    mem_line_arbiter arb (
        .clk(clk),
        .rst(rst),
        .iRdReq(i_rd_req),
        .dRdReq(d_rd_req),
        .dWrReq(d_wr_req),
        .accept(accept),
        .grant(grant)
    );

    assign accept = state == IDLE && grant != GNT_NONE;
    assign reqAddr = grant == GNT_DWR ? d_wr_addr : grant == GNT_DRD ? d_rd_addr : i_rd_addr;
    assign unusedAddr = ^reqAddr;
    // With LATENCY==1 the array is read on the accept edge, before idx/curGnt are latched.
    assign rdIdx = state == IDLE ? reqAddr[OFF+:DEPTH_LOG2] : idx;
    assign rdGnt = state == IDLE ? grant : curGnt;

    always_comb begin
        nextState = state;
        nextState = state == IDLE ? (accept ? (LATENCY == 1 ? RESP : WAIT) : IDLE) :
                    state == WAIT ? (cnt == CW'(1) ? RESP : WAIT) : IDLE;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt <= '0;
            curGnt <= GNT_NONE;
            idx <= '0;
            wrLine <= '0;
            i_rd_data <= '0;
            d_rd_data <= '0;
        end else begin
            state <= nextState;
            if (accept) begin
                curGnt <= grant;
                idx <= reqAddr[OFF+:DEPTH_LOG2];
                cnt <= CW'(LATENCY - 1);
                if (grant == GNT_DWR)
                    wrLine <= d_wr_line;
            end else if (state == WAIT) begin
                cnt <= cnt - CW'(1);
            end
            if (nextState == RESP && rdGnt == GNT_IRD)
                i_rd_data <= mem[rdIdx];
            if (nextState == RESP && rdGnt == GNT_DRD)
                d_rd_data <= mem[rdIdx];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && state == RESP && curGnt == GNT_DWR)
            mem[idx] <= wrLine;
    end

    assign i_rd_valid = state == RESP && curGnt == GNT_IRD;
    assign d_rd_valid = state == RESP && curGnt == GNT_DRD;
    assign d_wr_ack = state == RESP && curGnt == GNT_DWR;

`ifdef MEM_LINE_SERVER_STATS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            stat_rd_cnt <= '0;
            stat_wr_cnt <= '0;
            stat_busy_cyc <= '0;
        end else begin
            if (state == RESP && curGnt != GNT_DWR)
                stat_rd_cnt <= stat_rd_cnt + 32'd1;
            if (state == RESP && curGnt == GNT_DWR)
                stat_wr_cnt <= stat_wr_cnt + 32'd1;
            if (state != IDLE)
                stat_busy_cyc <= stat_busy_cyc + 32'd1;
        end
    end
`endif
endmodule

// File: tb/tb_mem_line_server.sv
// tb_mem_line_server: randomized checks of the line server against an array-and-ordering reference model.
module tb_mem_line_server;
    import mem_pkg::*;
    localparam int L = 4;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic iReq, dReq, wReq, iReqB, dReqB, wReqB;
    logic [ARCH_BITS-1:0] iAddr, dAddr, wAddr, iAddrB, dAddrB, wAddrB;
    logic [LINE_BITS-1:0] wLine, wLineB, iData, dData, iDataB, dDataB;
    logic iValid, dValid, wAck, iValidB, dValidB, wAckB;
`ifdef MEM_LINE_SERVER_STATS_EN
    logic [31:0] sRd, sWr, sBusy, sRdB, sWrB, sBusyB;
`endif
    int checks = 0;
    int errors = 0;
    logic [LINE_BITS-1:0] model [int];
    int pool [$];
    bit lastRdD;

    always #5 clk = ~clk;

    mem_line_server #(.DEPTH_LOG2(12), .LATENCY(L)) dut (
        .clk(clk), .rst(rst),
        .i_rd_req(iReq), .i_rd_addr(iAddr), .i_rd_data(iData), .i_rd_valid(iValid),
        .d_rd_req(dReq), .d_rd_addr(dAddr), .d_rd_data(dData), .d_rd_valid(dValid),
        .d_wr_req(wReq), .d_wr_addr(wAddr), .d_wr_line(wLine), .d_wr_ack(wAck)
`ifdef MEM_LINE_SERVER_STATS_EN
        , .stat_rd_cnt(sRd), .stat_wr_cnt(sWr), .stat_busy_cyc(sBusy)
`endif
    );

    mem_line_server #(.DEPTH_LOG2(12), .LATENCY(1)) dutB (
        .clk(clk), .rst(rst),
        .i_rd_req(iReqB), .i_rd_addr(iAddrB), .i_rd_data(iDataB), .i_rd_valid(iValidB),
        .d_rd_req(dReqB), .d_rd_addr(dAddrB), .d_rd_data(dDataB), .d_rd_valid(dValidB),
        .d_wr_req(wReqB), .d_wr_addr(wAddrB), .d_wr_line(wLineB), .d_wr_ack(wAckB)
`ifdef MEM_LINE_SERVER_STATS_EN
        , .stat_rd_cnt(sRdB), .stat_wr_cnt(sWrB), .stat_busy_cyc(sBusyB)
`endif
    );

    function automatic int ix(input logic [31:0] a);
        return int'((a / 32'd16) % 32'd4096);
    endfunction

    function automatic logic [127:0] rndLine();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic doReset;
        rst = 1'b1;
        {iReq, dReq, wReq, iReqB, dReqB, wReqB} = '0;
        {iAddr, dAddr, wAddr, iAddrB, dAddrB, wAddrB} = '0;
        {wLine, wLineB} = '0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        lastRdD = 1'b0;
    endtask

    // Raise a set of requests together; the model predicts service order, pulse cycles and data.
    task automatic burst(input string name, input bit ri, input bit rd, input bit rw,
                         input logic [31:0] ai, input logic [31:0] ad, input logic [31:0] aw,
                         input logic [127:0] ln);
        int exp [$];
        int n = 0;
        int cyc = 0;
        int got;
        logic [127:0] obs, want;
        if (rw) exp.push_back(2);
        if (ri && rd) begin
            if (lastRdD) begin exp.push_back(0); exp.push_back(1); end
            else begin exp.push_back(1); exp.push_back(0); end
        end else if (ri) exp.push_back(0);
        else if (rd) exp.push_back(1);
        iAddr = ai; dAddr = ad; wAddr = aw; wLine = ln;
        iReq = ri; dReq = rd; wReq = rw;
        while (n < exp.size() && cyc < 64) begin
            @(posedge clk);
            #1;
            cyc++;
            if (iValid || dValid || wAck) begin
                got = wAck ? 2 : dValid ? 1 : 0;
                checks++;
                if (int'(iValid) + int'(dValid) + int'(wAck) != 1 || got != exp[n] || cyc != (n + 1) * (L + 1) - 1) begin
                    errors++;
                    $display("FAIL %s_order pulse %0d: got port %0d (i%b d%b w%b) at cycle %0d, want port %0d at cycle %0d",
                             name, n, got, iValid, dValid, wAck, cyc, exp[n], (n + 1) * (L + 1) - 1);
                end
                if (got == 0 || got == 1) begin
                    obs = got == 0 ? iData : dData;
                    want = model[ix(got == 0 ? ai : ad)];
                    checks++;
                    if (obs !== want) begin
                        errors++;
                        $display("FAIL %s_data port %0d: got %h want %h", name, got, obs, want);
                    end
                    lastRdD = got == 1;
                end else begin
                    model[ix(aw)] = ln;
                end
                if (got == 0) iReq = 1'b0;
                else if (got == 1) dReq = 1'b0;
                else wReq = 1'b0;
                n++;
            end
        end
        if (n < exp.size()) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout got %0d pulses want %0d", name, n, exp.size());
        end
        {iReq, dReq, wReq} = '0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        doReset();
        checks++;
        if ({iValid, dValid, wAck, iValidB, dValidB, wAckB} !== 6'b0) begin
            errors++;
            $display("FAIL reset_pulses got %b want 000000", {iValid, dValid, wAck, iValidB, dValidB, wAckB});
        end
        checks++;
        if (iData !== '0 || dData !== '0 || iDataB !== '0 || dDataB !== '0) begin
            errors++;
            $display("FAIL reset_data got %h %h %h %h want all zero", iData, dData, iDataB, dDataB);
        end
`ifdef MEM_LINE_SERVER_STATS_EN
        checks++;
        if ({sRd, sWr, sBusy} !== 96'b0) begin
            errors++;
            $display("FAIL reset_stats got %0d %0d %0d want 0 0 0", sRd, sWr, sBusy);
        end
`endif
    endtask

    task automatic test_preload;
        int id;
        burst("preload_010", 0, 0, 1, 0, 0, 32'h100, {16{8'hA5}});
        burst("preload_020", 0, 0, 1, 0, 0, 32'h200, rndLine());
        burst("preload_030", 0, 0, 1, 0, 0, 32'h300, rndLine());
        burst("preload_040", 0, 0, 1, 0, 0, 32'h400, rndLine());
        for (int k = 0; k < 8; k++) begin
            id = int'($urandom_range(0, 4095));
            pool.push_back(id);
            burst("preload_rand", 0, 0, 1, 0, 0, $urandom & 32'hFFFF0000 | 32'(id) << 4, rndLine());
        end
    endtask

    task automatic test_single_fill;
        burst("single_fill", 1, 0, 0, 32'h100, 0, 0, 0);
    endtask

    task automatic test_eviction;
        burst("eviction", 0, 1, 1, 0, 32'h300, 32'h200, {4{32'hDEADBEEF}});
        burst("raw_after_evict", 0, 1, 0, 0, 32'h208, 0, 0);
    endtask

    task automatic test_fairness;
        int cyc = 0;
        int n = 0;
        int want;
        doReset();
        iAddr = 32'(pool[0]) << 4;
        dAddr = 32'(pool[1]) << 4;
        iReq = 1'b1;
        dReq = 1'b1;
        while (n < 6 && cyc < 100) begin
            @(posedge clk);
            #1;
            cyc++;
            if (iValid || dValid) begin
                want = n % 2 == 0 ? 1 : 0;
                checks++;
                if ((iValid && dValid) || int'(dValid) != want || cyc != (n + 1) * (L + 1) - 1 ||
                    (dValid ? dData : iData) !== model[want == 1 ? pool[1] : pool[0]]) begin
                    errors++;
                    $display("FAIL fairness_%0d got i%b d%b at cycle %0d, want d=%0d at cycle %0d with matching data",
                             n, iValid, dValid, cyc, want, (n + 1) * (L + 1) - 1);
                end
                n++;
            end
        end
        if (n < 6) begin
            checks++;
            errors++;
            $display("FAIL fairness_timeout got %0d pulses want 6", n);
        end
        {iReq, dReq} = '0;
        lastRdD = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset_mid;
        bit sawAck = 1'b0;
        wAddr = 32'h400;
        wLine = rndLine();
        wReq = 1'b1;
        @(posedge clk);
        #1;
        sawAck |= wAck;
        @(posedge clk);
        #1;
        sawAck |= wAck;
        rst = 1'b1;
        wReq = 1'b0;
        @(posedge clk);
        #1;
        sawAck |= wAck;
        rst = 1'b0;
        lastRdD = 1'b0;
        checks++;
        if (sawAck) begin
            errors++;
            $display("FAIL reset_mid_ack got ack=1 want 0");
        end
        burst("reset_mid_read", 1, 0, 0, 32'h400, 0, 0, 0);
    endtask

    task automatic test_random;
        int r;
        logic [31:0] ai, ad, aw;
        for (int k = 0; k < 40; k++) begin
            r = int'($urandom_range(1, 7));
            ai = $urandom & 32'hFFFF000F | 32'(pool[$urandom_range(0, pool.size() - 1)]) << 4;
            ad = $urandom & 32'hFFFF000F | 32'(pool[$urandom_range(0, pool.size() - 1)]) << 4;
            aw = $urandom & 32'hFFFF0000 | 32'(pool[$urandom_range(0, pool.size() - 1)]) << 4;
            burst("random", r[0], r[1], r[2], ai, ad, aw, rndLine());
        end
    endtask

    task automatic test_latency1;
        int cyc;
        logic [127:0] ln;
        ln = rndLine();
        wAddrB = 32'h10;
        wLineB = ln;
        wReqB = 1'b1;
        cyc = 0;
        do begin @(posedge clk); #1; cyc++; end while (!wAckB && cyc < 16);
        wReqB = 1'b0;
        checks++;
        if (!wAckB || cyc != 1) begin
            errors++;
            $display("FAIL lat1_write got ack=%b at cycle %0d want ack at cycle 1", wAckB, cyc);
        end
        @(posedge clk);
        #1;
        iAddrB = 32'hFFFF_0010;
        iReqB = 1'b1;
        cyc = 0;
        do begin @(posedge clk); #1; cyc++; end while (!iValidB && cyc < 16);
        iReqB = 1'b0;
        checks++;
        if (!iValidB || cyc != 1 || iDataB !== ln) begin
            errors++;
            $display("FAIL lat1_alias_read got valid=%b cycle %0d data %h want cycle 1 data %h", iValidB, cyc, iDataB, ln);
        end
        @(posedge clk);
        #1;
        dAddrB = 32'h0000_001C;
        dReqB = 1'b1;
        cyc = 0;
        do begin @(posedge clk); #1; cyc++; end while (!dValidB && cyc < 16);
        dReqB = 1'b0;
        checks++;
        if (!dValidB || cyc != 1 || dDataB !== ln) begin
            errors++;
            $display("FAIL lat1_d_read got valid=%b cycle %0d data %h want cycle 1 data %h", dValidB, cyc, dDataB, ln);
        end
        @(posedge clk);
        #1;
    endtask

`ifdef MEM_LINE_SERVER_STATS_EN
    task automatic test_stats;
        doReset();
        burst("stats_w0", 0, 0, 1, 0, 0, 32'(pool[2]) << 4, rndLine());
        burst("stats_w1", 0, 0, 1, 0, 0, 32'(pool[3]) << 4, rndLine());
        burst("stats_r0", 1, 0, 0, 32'(pool[2]) << 4, 0, 0, 0);
        burst("stats_r1", 0, 1, 0, 0, 32'(pool[3]) << 4, 0, 0);
        burst("stats_r2", 1, 0, 0, 32'(pool[4]) << 4, 0, 0, 0);
        checks++;
        if (sRd !== 32'd3 || sWr !== 32'd2 || sBusy !== 32'(5 * L)) begin
            errors++;
            $display("FAIL stats got rd=%0d wr=%0d busy=%0d want 3 2 %0d", sRd, sWr, sBusy, 5 * L);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_preload();
        test_single_fill();
        test_eviction();
        test_fairness();
        test_reset_mid();
        test_random();
        test_latency1();
`ifdef MEM_LINE_SERVER_STATS_EN
        test_stats();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
